alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests from two independent requesters (port 0: EX-stage datapath, port 1: auxiliary address/compare unit), grants the ALU round-robin, and drives the ALU's `aluop`/`a`/`b` inputs from registered operands. It captures `out`/`zero`/`oflow` and returns them to the winning requester with a valid/ready response handshake. The ALU sits outside this block; the arbiter connects to it port for port.

---
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared ALU.
// Two requesters, one op in flight, registered operands and results.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zero,
    output logic             rsp_oflow,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_oflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             owner;
    logic             prio;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] out_r;
    logic             zero_r;
    logic             oflow_r;

    logic any_req;
    logic winner;
    logic rsp_take;

    // Winner pick: a lone request wins outright, a tie goes to prio.
    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = prio;
        end else begin
            winner = req1_valid;
        end
        req0_ready = (state == IDLE) && req0_valid && !winner;
        req1_ready = (state == IDLE) && winner;
        rsp0_valid = (state == RESP) && !owner;
        rsp1_valid = (state == RESP) && owner;
        rsp_take   = owner ? rsp1_ready : rsp0_ready;
    end

    assign alu_op    = op_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign rsp_out   = out_r;
    assign rsp_zero  = zero_r;
    assign rsp_oflow = oflow_r;

    // Sequencer: accept, run the ALU for one cycle, hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            prio    <= 1'b0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            out_r   <= '0;
            zero_r  <= 1'b0;
            oflow_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        op_r  <= winner ? req1_op : req0_op;
                        a_r   <= winner ? req1_a : req0_a;
                        b_r   <= winner ? req1_b : req0_b;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_r   <= alu_out;
                    zero_r  <= alu_zero;
                    oflow_r <= alu_oflow;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural ALU plus a transaction-level
// round-robin model; directed cases followed by random traffic.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req1_a, req0_b, req1_b;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_out;
    logic         rsp_zero, rsp_oflow;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_zero, alu_oflow;

    int n_checks = 0;
    int n_errors = 0;
    int exp_prio = 0;
    int obs_win;
    logic [W-1:0] obs_out;
    logic         obs_zero, obs_oflow;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req1_a(req1_a),
        .req0_b(req0_b), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_oflow(rsp_oflow),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_oflow(alu_oflow)
    );

    // Returns {oflow, zero, out} for one ALU operation.
    function automatic logic [W+1:0] alu_ref(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        logic of;
        logic lt;
        r  = '0;
        of = 1'b0;
        lt = $signed(a) < $signed(b);
        case (op)
            3'd0: begin
                r  = a + b;
                of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: r = a | b;
            3'd2: r = {{(W-1){1'b0}}, lt};
            3'd3: r = a - b;
            3'd4: r = {b[15:0], 16'h0000};
            default: r = '0;
        endcase
        return {of, (r == '0), r};
    endfunction

    assign {alu_oflow, alu_zero, alu_out} = alu_ref(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (p == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // After reset: IDLE with prio 0, all registered outputs cleared.
    task automatic reset_check(input string tag);
        chk({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_rsp_out"}, rsp_out, 32'd0);
        chk({tag, "_rsp_flags"}, 32'({rsp_oflow, rsp_zero}), 32'd0);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 32'(req0_valid));
        chk({tag, "_req1_ready"}, 32'(req1_ready),
            32'(req1_valid && !req0_valid));
    endtask

    // One full transaction starting in an IDLE cycle with requests driven.
    task automatic transact(input int hold);
        int win;
        logic [2:0] op;
        logic [W-1:0] a, b;
        logic [W+1:0] r;
        @(negedge clk);
        if (req0_valid && req1_valid) win = exp_prio;
        else if (req1_valid) win = 1;
        else win = 0;
        chk("accept_req0_ready", 32'(req0_ready), 32'(win == 0));
        chk("accept_req1_ready", 32'(req1_ready), 32'(win == 1));
        op = (win == 1) ? req1_op : req0_op;
        a  = (win == 1) ? req1_a : req0_a;
        b  = (win == 1) ? req1_b : req0_b;
        r  = alu_ref(op, a, b);
        obs_win = win;
        tick();
        if (win == 1) req1_valid = 1'b0;
        else req0_valid = 1'b0;
        @(negedge clk);
        chk("exec_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("exec_alu_op", 32'(alu_op), 32'(op));
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        tick();
        for (int i = 0; i <= hold; i++) begin
            if (win == 1) begin
                rsp1_ready = (i == hold);
                rsp0_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp0_ready = (i == hold);
                rsp1_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}),
                (win == 1) ? 32'd2 : 32'd1);
            chk("rsp_out", rsp_out, r[W-1:0]);
            chk("rsp_zero", 32'(rsp_zero), 32'(r[W]));
            chk("rsp_oflow", 32'(rsp_oflow), 32'(r[W+1]));
            chk("rsp_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
            obs_out   = rsp_out;
            obs_zero  = rsp_zero;
            obs_oflow = rsp_oflow;
            tick();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        exp_prio = 1 - win;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        reset_check("por");
        rst = 1'b0;
        exp_prio = 0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req1_op = 0;
        req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;

        do_reset();

        drive(0, 3'd0, 32'd7, 32'd5);
        transact(0);
        chk("add_out", obs_out, 32'd12);
        chk("add_flags", 32'({obs_oflow, obs_zero}), 32'd0);

        do_reset();
        drive(0, 3'd3, 32'd9, 32'd9);
        drive(1, 3'd1, 32'h0000_00F0, 32'h0000_000F);
        transact(0);
        chk("tie_first_port", 32'(obs_win), 32'd0);
        chk("sub_out", obs_out, 32'd0);
        chk("sub_zero", 32'(obs_zero), 32'd1);
        drive(0, 3'd3, 32'd9, 32'd9);
        transact(0);
        chk("tie_second_port", 32'(obs_win), 32'd1);
        chk("or_out", obs_out, 32'h0000_00FF);
        transact(0);
        chk("tie_third_port", 32'(obs_win), 32'd0);

        drive(1, 3'd0, 32'h7FFF_FFFF, 32'd1);
        transact(0);
        chk("ovf_out", obs_out, 32'h8000_0000);
        chk("ovf_flag", 32'(obs_oflow), 32'd1);

        drive(0, 3'd2, 32'hFFFF_FFFF, 32'd1);
        transact(0);
        chk("slt_out", obs_out, 32'd1);
        drive(1, 3'd4, 32'd0, 32'h0000_1234);
        transact(0);
        chk("lui_out", obs_out, 32'h1234_0000);

        drive(0, 3'd0, 32'd1000, 32'd24);
        drive(1, 3'd1, 32'h0F00, 32'h00F0);
        transact(5);
        chk("bp_port", 32'(obs_win), 32'd0);
        chk("bp_out", obs_out, 32'd1024);
        transact(0);
        chk("bp_waiter_port", 32'(obs_win), 32'd1);

        drive(0, 3'd5, 32'd3, 32'd4);
        transact(0);
        chk("undef_out", obs_out, 32'd0);
        chk("undef_zero", 32'(obs_zero), 32'd1);

        drive(0, 3'd0, 32'd100, 32'd23);
        @(negedge clk);
        chk("rx_accept", 32'(req0_ready), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        reset_check("rst_exec");
        exp_prio = 0;
        transact(0);
        chk("rx_reaccept_out", obs_out, 32'd123);

        drive(0, 3'd3, 32'd50, 32'd8);
        @(negedge clk);
        chk("rr_accept", 32'(req0_ready), 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("rr_in_resp", 32'(rsp0_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        reset_check("rst_resp");
        exp_prio = 0;
        transact(1);
        chk("rr_reaccept_out", obs_out, 32'd42);

        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++) begin
                logic busy;
                busy = (p == 0) ? req0_valid : req1_valid;
                if (!busy && $urandom_range(0, 1) == 1) begin
                    drive(p, 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF
                                                      : $urandom(),
                          ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom());
                end
            end
            if (!req0_valid && !req1_valid) begin
                drive($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                      $urandom(), $urandom());
            end
            transact($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
